// File: rtl/eaglesong_pkg.sv
// Shared types and defaults for the Eaglesong absorb front end.
// Contents: default rate and delimiter, FSM state enum, the 32-bit word type,
// and a helper that says how many bytes of a block belong to a given word.
package eaglesong_pkg;

    localparam int         RATE_WORDS_DEFAULT = 8;
    localparam logic [7:0] DELIM_DEFAULT      = 8'h06;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EMIT = 2'd1,
        PAD  = 2'd2
    } absorb_state_t;

    typedef logic [31:0] es_word_t;

    // Number of filled bytes (0..4) that land in word word_idx when the block
    // holds fill bytes in total (message bytes plus delimiter).
    function automatic logic [2:0] lane_count(input int unsigned fill, input int unsigned word_idx);
        if (fill >= 4 * (word_idx + 1)) begin
            return 3'd4;
        end else if (fill > 4 * word_idx) begin
            return 3'(fill - 4 * word_idx);
        end else begin
            return 3'd0;
        end
    endfunction

endpackage

// File: rtl/eaglesong_word_packer.sv
// Purpose: packs up to 4 byte lanes into one 32-bit word by shift-in (w = (w << 8) | byte).
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: lanes - byte k (message order) at lanes[k*8 +: 8]; count - bytes to shift in (0..4);
//        word  - result, right-aligned when count < 4, zero when count == 0.
module eaglesong_word_packer
    import eaglesong_pkg::*;
(
    input  logic [31:0] lanes,
    input  logic [2:0]  count,
    output es_word_t    word
);

    always_comb begin
        word = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < count) begin
                word = {word[23:0], lanes[k*8 +: 8]};
            end
        end
    end

endmodule

// File: rtl/eaglesong_absorb.sv
// Purpose: streams message bytes into RATE_WORDS x 32-bit rate blocks, appends the delimiter, hands blocks on.
// Latency: blk_valid rises the cycle after the beat that completes a block; one dead cycle per block.
// Backpressure: in_ready drops while a block waits for blk_ready; outputs hold until the handshake.
// Ports: clk/rst (sync, active high); in_valid/in_ready/in_data/in_nbytes/in_last message beats;
//        blk_valid/blk_ready/blk_words/blk_first/blk_last rate blocks to the permutation core.
// Option: EAGLESONG_ABSORB_LEN_EN adds msg_len[63:0], the running byte count of the current message.
module eaglesong_absorb_seq
    import eaglesong_pkg::*;
#(
    parameter int         RATE_WORDS = RATE_WORDS_DEFAULT,
    parameter int         IN_BYTES   = 4,
    parameter logic [7:0] DELIM      = DELIM_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_BYTES*8-1:0]     in_data,
    input  logic [$clog2(IN_BYTES):0] in_nbytes,
    input  logic                      in_last,
    output logic                      blk_valid,
    input  logic                      blk_ready,
    output es_word_t                  blk_words [RATE_WORDS],
    output logic                      blk_first,
    output logic                      blk_last
`ifdef EAGLESONG_ABSORB_LEN_EN
    ,
    output logic [63:0]               msg_len
`endif
);

    localparam int RATE_BYTES = 4 * RATE_WORDS;
    localparam int CNT_W      = $clog2(RATE_BYTES + 1);
    localparam int IDX_W      = $clog2(RATE_BYTES);
    localparam int NB_W       = $clog2(IN_BYTES) + 1;

    if (RATE_BYTES % IN_BYTES != 0) begin : g_bad_cfg
        $error("RATE_BYTES must be a multiple of IN_BYTES");
    end

    absorb_state_t    state;
    logic [7:0]       data_buf [RATE_BYTES];
    logic [CNT_W-1:0] byte_cnt;     // bytes held in the block, delimiter included
    logic [CNT_W-1:0] fill_sum;
    logic             pad_pending;  // message ended exactly on a block boundary

    assign fill_sum = byte_cnt + CNT_W'(in_nbytes);

    // Words past the delimiter see count 0 and read as zero, so stale buffer
    // contents never leak into a block.
    for (genvar j = 0; j < RATE_WORDS; j++) begin : g_word
        logic [31:0] lanes;
        logic [2:0]  count;
        assign lanes = {data_buf[4*j+3], data_buf[4*j+2], data_buf[4*j+1], data_buf[4*j]};
        assign count = lane_count(32'(byte_cnt), 32'(j));
        eaglesong_word_packer u_packer (
            .lanes (lanes),
            .count (count),
            .word  (blk_words[j])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            in_ready    <= 1'b0;
            blk_valid   <= 1'b0;
            blk_first   <= 1'b1;
            blk_last    <= 1'b0;
            pad_pending <= 1'b0;
            byte_cnt    <= '0;
            for (int b = 0; b < RATE_BYTES; b++) data_buf[b] <= '0;
        end else begin
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        // Beats before the last are full, so byte_cnt is beat-aligned here.
                        for (int i = 0; i < IN_BYTES; i++) begin
                            if (NB_W'(i) < in_nbytes) begin
                                data_buf[IDX_W'(byte_cnt) + IDX_W'(i)] <= in_data[i*8 +: 8];
                            end
                        end
                        if (in_last && (fill_sum < CNT_W'(RATE_BYTES))) begin
                            data_buf[IDX_W'(fill_sum)] <= DELIM;
                            byte_cnt  <= fill_sum + CNT_W'(1);
                            blk_last  <= 1'b1;
                            blk_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= EMIT;
                        end else if (fill_sum == CNT_W'(RATE_BYTES)) begin
                            // A full final block still needs a delimiter-only block after it.
                            byte_cnt    <= fill_sum;
                            pad_pending <= in_last;
                            blk_valid   <= 1'b1;
                            in_ready    <= 1'b0;
                            state       <= EMIT;
                        end else begin
                            byte_cnt <= fill_sum;
                        end
                    end
                end
                EMIT: begin
                    if (blk_ready) begin
                        for (int b = 0; b < RATE_BYTES; b++) data_buf[b] <= '0;
                        if (pad_pending) begin
                            data_buf[0] <= DELIM;
                            byte_cnt    <= CNT_W'(1);
                            blk_first   <= 1'b0;
                            blk_last    <= 1'b1;
                            state       <= PAD;
                        end else begin
                            byte_cnt  <= '0;
                            blk_first <= blk_last;
                            blk_last  <= 1'b0;
                            blk_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= FILL;
                        end
                    end
                end
                PAD: begin
                    if (blk_ready) begin
                        for (int b = 0; b < RATE_BYTES; b++) data_buf[b] <= '0;
                        byte_cnt    <= '0;
                        pad_pending <= 1'b0;
                        blk_first   <= 1'b1;
                        blk_last    <= 1'b0;
                        blk_valid   <= 1'b0;
                        in_ready    <= 1'b1;
                        state       <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef EAGLESONG_ABSORB_LEN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_len <= '0;
        end else if ((state == FILL) && in_valid && in_ready) begin
            msg_len <= msg_len + 64'(in_nbytes);
        end else if (blk_valid && blk_ready && blk_last) begin
            msg_len <= '0;
        end
    end
`else
    // Length counter not built.
`endif

    // A non-final beat must carry a full IN_BYTES.
    a_full_beat: assert property (@(posedge clk) disable iff (rst)
        (in_valid && in_ready && !in_last) |-> (in_nbytes == NB_W'(IN_BYTES)));

endmodule

// File: tb/tb_eaglesong_absorb_seq.sv
module tb_eaglesong_absorb_seq;

    localparam int         RW    = 8;
    localparam logic [7:0] DELIM = 8'h06;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_last;
    logic [31:0] in_data;
    logic [2:0]  in_nbytes;
    logic        blk_valid, blk_ready, blk_first, blk_last;
    logic [31:0] blk_words [RW];

    typedef struct packed {
        logic [255:0] words;
        logic         first;
        logic         last;
        logic         nxt_pad;
    } exp_blk_t;

    exp_blk_t     exp_q [$];
    logic [255:0] hs_words [$];
    logic [1:0]   hs_flags [$];
    logic [7:0]   msg [$];
    int           total = 0;
    int           bad   = 0;
    logic         hold_ready = 1'b0;

    eaglesong_absorb_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_nbytes (in_nbytes),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_words (blk_words),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [263:0] act, input logic [263:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got no event, expected one within the cycle budget", nm);
    endtask

    function automatic logic [255:0] cur_words();
        logic [255:0] v;
        for (int j = 0; j < RW; j++) v[j*32 +: 32] = blk_words[j];
        return v;
    endfunction

    // Reference: a message of L bytes becomes L/32+1 blocks; each block takes
    // its slice of the message, the final one gets the delimiter, and each
    // word is the big-endian value of the (up to 4) bytes it holds.
    function automatic void model_push();
        int L  = msg.size();
        int nb = L / 32 + 1;
        for (int k = 0; k < nb; k++) begin
            exp_blk_t   e;
            logic [7:0] seg [$];
            seg = {};
            for (int b = 32 * k; b < L && b < 32 * k + 32; b++) seg.push_back(msg[b]);
            if (k == nb - 1) seg.push_back(DELIM);
            e.words = '0;
            for (int j = 0; j < RW; j++) begin
                int          n;
                logic [31:0] w;
                n = seg.size() - 4 * j;
                if (n > 4) n = 4;
                if (n < 0) n = 0;
                w = 32'h0;
                for (int t = 0; t < n; t++) w = w + (32'(seg[4*j+t]) << (8 * (n - 1 - t)));
                e.words[j*32 +: 32] = w;
            end
            e.first   = (k == 0);
            e.last    = (k == nb - 1);
            e.nxt_pad = (k == nb - 2) && (L % 32 == 0);
            exp_q.push_back(e);
        end
    endfunction

    function automatic void set_seq(input int len, input int start);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'(start + i));
    endfunction

    // Drives msg as beats; limit < 0 sends all of it.
    task automatic send_msg(input int limit);
        int L      = msg.size();
        int nbeats = (L == 0) ? 1 : (L + 3) / 4;
        @(posedge clk); #1;
        for (int bt = 0; bt < nbeats && (limit < 0 || bt < limit); bt++) begin
            int n;
            int cyc;
            n = L - 4 * bt;
            if (n > 4) n = 4;
            in_data = 32'h0;
            for (int t = 0; t < n; t++) in_data[t*8 +: 8] = msg[4*bt+t];
            in_nbytes = 3'(n);
            in_last   = (bt == nbeats - 1);
            in_valid  = 1'b1;
            cyc = 0;
            @(negedge clk);
            while (!in_ready && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            if (!in_ready) fail_now("beat_accept");
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0; in_nbytes = 3'd0; in_data = 32'h0;
    endtask

    task automatic wait_hs(input int n);
        int c = 0;
        while (hs_words.size() < n && c < 300) begin
            @(negedge clk);
            c++;
        end
        if (hs_words.size() < n) fail_now("block_handshake");
    endtask

    initial begin
        blk_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            blk_ready = !hold_ready;
        end
    end

    // Compare process: every block handshake against the model, plus
    // stability under stall and the state seen the cycle after a handshake.
    initial begin
        logic         prev_stall = 1'b0;
        logic [263:0] prev_blk;
        logic         post_hs = 1'b0;
        logic         post_pad = 1'b0;
        exp_blk_t     e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                post_hs    = 1'b0;
                continue;
            end
            if (post_hs) begin
                if (post_pad) chk("pad_follows", blk_valid, 1);
                else          chk("rdy_after_hs", {blk_valid, in_ready}, 2'b01);
                post_hs = 1'b0;
            end
            if (blk_valid) begin
                chk("in_ready_low_in_emit", in_ready, 0);
                if (prev_stall) chk("stall_stable", {cur_words(), blk_first, blk_last, 6'b0}, prev_blk);
                if (blk_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_block");
                    end else begin
                        e = exp_q.pop_front();
                        chk("blk_words", cur_words(), e.words);
                        chk("blk_flags", {blk_first, blk_last}, {e.first, e.last});
                        post_hs  = 1'b1;
                        post_pad = e.nxt_pad;
                    end
                    hs_words.push_back(cur_words());
                    hs_flags.push_back({blk_first, blk_last});
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_blk   = {cur_words(), blk_first, blk_last, 6'b0};
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected one before the time limit");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_nbytes = 3'd0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_blk_valid", blk_valid, 0);
        chk("rst_flags", {blk_first, blk_last}, 2'b10);
        chk("rst_words", cur_words(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rdy_after_rst", in_ready, 1);

        // 4-byte message.
        base = hs_words.size();
        set_seq(4, 0); model_push(); send_msg(-1); wait_hs(base + 1);
        chk("t1_w0", hs_words[base][31:0], 32'h00010203);
        chk("t1_w1", hs_words[base][63:32], 32'h00000006);
        chk("t1_rest", hs_words[base][255:64], 0);
        chk("t1_flags", hs_flags[base], 2'b11);

        // 1-byte message AB.
        base = hs_words.size();
        msg.delete(); msg.push_back(8'hAB); model_push(); send_msg(-1); wait_hs(base + 1);
        chk("t2_w0", hs_words[base][31:0], 32'h0000AB06);
        chk("t2_rest", hs_words[base][255:32], 0);

        // 32 bytes: full block then delimiter-only block.
        base = hs_words.size();
        set_seq(32, 0); model_push(); send_msg(-1); wait_hs(base + 2);
        chk("t3_w0", hs_words[base][31:0], 32'h00010203);
        chk("t3_w7", hs_words[base][255:224], 32'h1C1D1E1F);
        chk("t3_flags1", hs_flags[base], 2'b10);
        chk("t3_pad", hs_words[base+1], 256'h6);
        chk("t3_flags2", hs_flags[base+1], 2'b01);

        // 40 bytes.
        base = hs_words.size();
        set_seq(40, 0); model_push(); send_msg(-1); wait_hs(base + 2);
        chk("t4_flags1", hs_flags[base], 2'b10);
        chk("t4_w0", hs_words[base+1][31:0], 32'h20212223);
        chk("t4_w1", hs_words[base+1][63:32], 32'h24252627);
        chk("t4_w2", hs_words[base+1][95:64], 32'h00000006);
        chk("t4_flags2", hs_flags[base+1], 2'b01);

        // 31 bytes (delimiter in the last byte) and the empty message.
        base = hs_words.size();
        set_seq(31, 0); model_push(); send_msg(-1);
        msg.delete(); model_push(); send_msg(-1); wait_hs(base + 2);
        chk("t31_w7", hs_words[base][255:224], 32'h1C1D1E06);
        chk("empty_blk", hs_words[base+1], 256'h6);
        chk("empty_flags", hs_flags[base+1], 2'b11);

        // Stall in EMIT with a beat offered, then back-to-back messages.
        base = hs_words.size();
        hold_ready = 1'b1;
        set_seq(5, 8'h50); model_push(); send_msg(-1);
        in_valid = 1'b1; in_data = 32'hEE; in_nbytes = 3'd1; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_valid_rdy", {blk_valid, in_ready}, 2'b10);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 32'h0; in_nbytes = 3'd0; in_last = 1'b0;
        hold_ready = 1'b0;
        wait_hs(base + 1);
        chk("t5_w0", hs_words[base][31:0], 32'h50515253);
        chk("t5_w1", hs_words[base][63:32], 32'h00005406);
        set_seq(36, 8'h60); model_push(); send_msg(-1);
        set_seq(2, 8'h90);  model_push(); send_msg(-1);
        wait_hs(base + 4);
        chk("t5_b2b_first", hs_flags[base+3], 2'b11);

        // Reset while a 40-byte message's first block is stalled.
        hold_ready = 1'b1;
        set_seq(40, 0); send_msg(8);
        @(negedge clk);
        chk("t6_in_emit", blk_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("t6_rst_drop", {blk_valid, in_ready}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        hold_ready = 1'b0;
        base = hs_words.size();
        msg.delete(); msg.push_back(8'hAB); model_push(); send_msg(-1); wait_hs(base + 1);
        chk("t6_w0", hs_words[base][31:0], 32'h0000AB06);
        chk("t6_flags", hs_flags[base], 2'b11);

        repeat (5) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
